proc_core: RTL and testbench
============================

// Module: proc_core
// PURPOSE
// - Single-cycle RV32I-subset execution core. The instruction is supplied externally on ir each cycle; there is no fetch unit.
// - Contains a 32x32 register file, a byte-addressed data memory and a PC register.
// - Top of the processor datapath. Bench drives ir; results are observed on the writeback/PC ports.
// PARAMETERS
// - DMEM_BYTES  256  data memory size in bytes (power of 2); addresses wrap modulo DMEM_BYTES.
// - PC_RESET    0    PC value loaded on reset.
// PORTS
// - clk      in   1   single clock; all state updates on rising edge.
// - reset    in   1   synchronous, active-low reset (asserted when 0, sampled on rising edge of clk).
// - ir       in   32  instruction to execute this cycle (RISC-V encoding).
// - pc       out  32  current PC register.
// - wb_en    out  1   comb: register write occurs at next edge (rd!=0, valid writing instr).
// - wb_rd    out  5   comb: destination register index.
// - wb_data  out  32  comb: value written to rd.
// BEHAVIOUR
// - Reset (reset==0 at posedge): regs x1..x31=0, all DMEM bytes=0, pc=PC_RESET; wb_en is a comb output.
// - Otherwise, one instruction executes per posedge, using the ir present before the edge.
//   - Holding ir for N cycles executes it N times.
// - Decode: opcode=ir[6:0], rd=ir[11:7], f3=ir[14:12], rs1=ir[19:15], rs2=ir[24:20], f7=ir[31:25].
// - Immediate forms (all sign-extended to 32 bits):
//   - I: ir[31:20]
//   - S: {ir[31:25],ir[11:7]}
//   - B: {ir[31],ir[7],ir[30:25],ir[11:8],1'b0}
//   - J: {ir[31],ir[19:12],ir[20],ir[30:21],1'b0}
// - Supported instructions:
//   - 0010011 f3=000 ADDI: rd = rs1 + immI.
//   - 0110011 f3=000, f7=0000000 ADD: rd = rs1 + rs2. f7=0100000 SUB: rd = rs1 - rs2.
//   - 0000011 f3=000 LB: rd = sext(mem8[rs1+immI]). f3=010 LW: rd = mem32[(rs1+immI)&~3].
//   - 0100011 f3=000 SB: mem8[rs1+immS] = rs2[7:0]. f3=010 SW: mem32[(rs1+immS)&~3] = rs2.
//   - 1100011 f3=000 BEQ: if rs1==rs2, pc = pc + immB, else pc = pc + 4.
//   - 1101111 JAL: rd = pc + 4; pc = pc + immJ.
// - Arithmetic is 32-bit two's complement and wraps; no overflow flag.
// - x0 reads as 0 always; writes to x0 are discarded (wb_en=0).
// - Register reads are combinational. A write in cycle n is visible to the instruction in cycle n+1.
// - DMEM is little-endian. Reads are combinational and writes occur at the clock edge.
//   - Word accesses force addr[1:0]=0 (no misalign trap).
//   - Addresses are taken modulo DMEM_BYTES.
// - pc advances +4 every non-reset cycle, except on taken BEQ or JAL.
// - Unsupported opcode/f3/f7 combinations: treated as NOP; pc += 4, no register or memory write.
// - Reset has priority over any instruction in the same cycle. An in-progress store is discarded.
// - X on ir: no requirement beyond holding state after reset.
// TESTING
// - Reset: hold reset=0 two cycles -> pc=0, x1=0, mem word 4=0, wb_en=0 with ir=0.
// - ADDI x1,x0,5 (0x00500093) -> wb_en=1, wb_rd=1, wb_data=5; after edge x1=5, pc += 4.
// - SW x1,4(x0) (0x00102223), then LW x2,4(x0) (0x00402103) -> wb_rd=2, wb_data=5.
//   - Then LB x3,4(x0) -> wb_data=5. Store with x1=0xFFFFFF80 then LB -> 0xFFFFFF80.
// - x1=5, x2=2: ADD x1,x1,x2 -> 7. Then SUB x1,x1,x2 -> 5. SUB x4,x0,x1 -> 0xFFFFFFFB.
// - Branch at pc=P:
//   - BEQ x0,x1,+24 with x1=5 -> pc=P+4.
//   - BEQ x0,x0,+24 -> pc=P+24.
//   - JAL x1,+4000 -> x1=P+4, pc=P+4000.
// - ADDI x0,x0,7 -> wb_en=0 and x0 stays 0. Illegal opcode 0x0000007F -> NOP, pc += 4.

Source files
------------

// File: rtl/proc_core.sv
// Single-cycle RV32I-subset core: external instruction on ir, 32x32 register file,
// byte-addressed little-endian data memory and PC, all updated on the rising clock edge.
module proc_core #(
    parameter int          DMEM_BYTES = 256,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    output logic [31:0] pc,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam int AW = $clog2(DMEM_BYTES);

    typedef enum logic [6:0] {
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111
    } opcode_e;

    logic [31:0] regs [32];
    logic [7:0]  dmem [DMEM_BYTES];

    opcode_e     opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [AW-1:0] byte_addr;
    logic [AW-3:0] word_addr;
    logic [31:0] load_word;
    logic [31:0] next_pc;
    logic        store_byte, store_word;

    assign opcode = opcode_e'(ir[6:0]);
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

    // Only the low address bits matter, so the modulo wrap falls out of the truncated add.
    assign byte_addr = rs1_val[AW-1:0]
                     + ((opcode == OP_STORE) ? imm_s[AW-1:0] : imm_i[AW-1:0]);
    assign word_addr = byte_addr[AW-1:2];
    assign load_word = {dmem[{word_addr, 2'd3}], dmem[{word_addr, 2'd2}],
                        dmem[{word_addr, 2'd1}], dmem[{word_addr, 2'd0}]};

    assign wb_rd = rd;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        wb_en      = 1'b0;
        wb_data    = 32'h0;
        next_pc    = pc + 32'd4;
        store_byte = 1'b0;
        store_word = 1'b0;
        case (opcode)
            OP_IMM: if (f3 == 3'b000) begin
                wb_en   = 1'b1;
                wb_data = rs1_val + imm_i;
            end
            OP_REG: if (f3 == 3'b000 && f7 == 7'b0000000) begin
                wb_en   = 1'b1;
                wb_data = rs1_val + rs2_val;
            end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                wb_en   = 1'b1;
                wb_data = rs1_val - rs2_val;
            end
            OP_LOAD: if (f3 == 3'b000) begin
                wb_en   = 1'b1;
                wb_data = {{24{dmem[byte_addr][7]}}, dmem[byte_addr]};
            end else if (f3 == 3'b010) begin
                wb_en   = 1'b1;
                wb_data = load_word;
            end
            OP_STORE: begin
                store_byte = (f3 == 3'b000);
                store_word = (f3 == 3'b010);
            end
            OP_BRANCH: if (f3 == 3'b000 && rs1_val == rs2_val) begin
                next_pc = pc + imm_b;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            default: ;
        endcase
        if (rd == 5'd0) begin
            wb_en = 1'b0;
        end
    end

    // NOTE: state is written only with non-blocking assignments so every read in this
    // edge sees pre-edge values, matching the combinational decode above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= PC_RESET;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
            // NOTE: the data memory is deliberately cleared on reset, so it is built from
            // flops rather than a RAM macro that could not be initialised in one cycle.
            for (int i = 0; i < DMEM_BYTES; i++) begin
                dmem[i] <= 8'h00;
            end
        end else begin
            pc <= next_pc;
            if (wb_en) begin
                regs[rd] <= wb_data;
            end
            if (store_byte) begin
                dmem[byte_addr] <= rs2_val[7:0];
            end
            if (store_word) begin
                dmem[{word_addr, 2'd0}] <= rs2_val[7:0];
                dmem[{word_addr, 2'd1}] <= rs2_val[15:8];
                dmem[{word_addr, 2'd2}] <= rs2_val[23:16];
                dmem[{word_addr, 2'd3}] <= rs2_val[31:24];
            end
        end
    end

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: directed spec scenarios plus randomized instruction
// streams compared against an instruction-level reference model.
module tb_proc_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int vectors = 0;
    int miscompares = 0;

    proc_core dut (
        .clk     (clk),
        .reset   (reset),
        .ir      (ir),
        .pc      (pc),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    // Reference architectural state and the prediction for the instruction on ir.
    logic [31:0] m_regs [32];
    logic [7:0]  m_mem  [256];
    logic [31:0] m_pc;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_pc, e_val;
    int          e_st, e_addr;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] r1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [31:0] r2,
                                          input logic [31:0] r1, input logic [31:0] rd);
        return {f7, r2[4:0], r1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] r2,
                                          input logic [31:0] r1, input logic [31:0] f3);
        return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] r2,
                                          input logic [31:0] r1);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic model_reset();
        foreach (m_regs[k]) m_regs[k] = 32'h0;
        foreach (m_mem[k]) m_mem[k] = 8'h00;
        m_pc = 32'h0;
    endtask

    task automatic predict(input logic [31:0] i);
        int si, op, f3, f7, imm_i, imm_s, imm_b, imm_j;
        logic [31:0] a, b;
        si = int'(i);
        op = int'(i & 32'h7F);
        f3 = int'((i >> 12) & 7);
        f7 = int'(i >> 25);
        a  = m_regs[(i >> 15) & 31];
        b  = m_regs[(i >> 20) & 31];
        imm_i = si >>> 20;
        imm_s = ((si >>> 25) <<< 5) | int'((i >> 7) & 31);
        imm_b = ((si >>> 31) <<< 12) | int'(((i >> 7) & 1) << 11)
              | int'(((i >> 25) & 63) << 5) | int'(((i >> 8) & 15) << 1);
        imm_j = ((si >>> 31) <<< 20) | int'(((i >> 12) & 255) << 12)
              | int'(((i >> 20) & 1) << 11) | int'(((i >> 21) & 1023) << 1);
        e_en = 1'b0; e_rd = i[11:7]; e_data = 32'h0; e_pc = m_pc + 4; e_st = 0; e_addr = 0; e_val = b;
        case (op)
            'h13: if (f3 == 0) begin e_en = 1'b1; e_data = a + imm_i; end
            'h33: if (f3 == 0 && f7 == 0) begin e_en = 1'b1; e_data = a + b; end
                  else if (f3 == 0 && f7 == 32) begin e_en = 1'b1; e_data = a - b; end
            'h03: begin
                e_addr = int'((a + imm_i) & 255);
                if (f3 == 0) begin e_en = 1'b1; e_data = int'(byte'(m_mem[e_addr])); end
                else if (f3 == 2) begin
                    e_en = 1'b1;
                    for (int k = 0; k < 4; k++) e_data |= 32'(m_mem[(e_addr & ~3) + k]) << (8 * k);
                end
            end
            'h23: begin
                e_addr = int'((a + imm_s) & 255);
                e_st = (f3 == 0) ? 1 : (f3 == 2) ? 2 : 0;
            end
            'h63: if (f3 == 0 && a == b) e_pc = m_pc + imm_b;
            'h6F: begin e_en = 1'b1; e_data = m_pc + 4; e_pc = m_pc + imm_j; end
            default: ;
        endcase
        if (e_rd == 0) e_en = 1'b0;
    endtask

    task automatic commit();
        if (e_en) m_regs[e_rd] = e_data;
        if (e_st == 1) m_mem[e_addr] = e_val[7:0];
        if (e_st == 2) for (int k = 0; k < 4; k++) m_mem[(e_addr & ~3) + k] = 8'(e_val >> (8 * k));
        m_pc = e_pc;
    endtask

    // Called just after a falling edge: apply an instruction and let outputs settle.
    task automatic drive(input logic [31:0] instr);
        ir = instr;
        predict(instr);
        #1;
    endtask

    // Clock one edge, update the model, and re-predict the (possibly held) instruction.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) model_reset(); else commit();
        @(negedge clk);
        predict(ir);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ir = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        vectors++;
        if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        vectors++;
        if (wb_en !== 1'b0) begin miscompares++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
        reset = 1'b1;
        drive(enc_i(0, 1, 0, 5, 7'h13));
        vectors++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'h0}) begin
            miscompares++; $display("FAIL reset_x1: got en=%b rd=%0d data=%h want 1/5/0", wb_en, wb_rd, wb_data);
        end
        tick();
        drive(enc_i(4, 0, 2, 6, 7'h03));
        vectors++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd6, 32'h0}) begin
            miscompares++; $display("FAIL reset_mem4: got en=%b rd=%0d data=%h want 1/6/0", wb_en, wb_rd, wb_data);
        end
        tick();
        vectors++;
        if (pc !== 32'd8) begin miscompares++; $display("FAIL reset_pc_adv: got %h want 00000008", pc); end
    endtask

    task automatic test_addi();
        logic [31:0] p;
        drive(32'h00500093);
        vectors++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd1, 32'd5}) begin
            miscompares++; $display("FAIL addi_wb: got en=%b rd=%0d data=%h want 1/1/5", wb_en, wb_rd, wb_data);
        end
        p = m_pc;
        tick();
        vectors++;
        if (pc !== p + 32'd4) begin miscompares++; $display("FAIL addi_pc: got %h want %h", pc, p + 32'd4); end
    endtask

    task automatic test_mem();
        logic [31:0] exp_tab [5] = '{32'd5, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_FFFF};
        drive(32'h00102223); tick();
        drive(32'h00402103);
        vectors++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd2, 32'd5}) begin
            miscompares++; $display("FAIL lw_after_sw: got en=%b rd=%0d data=%h want 1/2/5", wb_en, wb_rd, wb_data);
        end
        tick();
        drive(enc_i(4, 0, 0, 3, 7'h03));
        vectors++;
        if (wb_data !== exp_tab[0]) begin miscompares++; $display("FAIL lb_pos: got %h want %h", wb_data, exp_tab[0]); end
        tick();
        drive(enc_i(-128, 0, 0, 1, 7'h13)); tick();
        drive(enc_s(4, 1, 0, 0)); tick();
        drive(enc_i(4, 0, 0, 3, 7'h03));
        vectors++;
        if (wb_data !== exp_tab[1]) begin miscompares++; $display("FAIL lb_neg: got %h want %h", wb_data, exp_tab[1]); end
        tick();
        drive(enc_i(4, 0, 2, 7, 7'h03));
        vectors++;
        if (wb_data !== exp_tab[2]) begin miscompares++; $display("FAIL lw_endian: got %h want %h", wb_data, exp_tab[2]); end
        tick();
        // Word store at 266: wraps to 10, aligned down to 8.
        drive(enc_i(266, 0, 0, 4, 7'h13)); tick();
        drive(enc_s(0, 1, 4, 2)); tick();
        drive(enc_i(8, 0, 2, 7, 7'h03));
        vectors++;
        if (wb_data !== exp_tab[3]) begin miscompares++; $display("FAIL sw_wrap_align: got %h want %h", wb_data, exp_tab[3]); end
        tick();
        drive(enc_i(11, 0, 0, 3, 7'h03));
        vectors++;
        if (wb_data !== exp_tab[4]) begin miscompares++; $display("FAIL lb_top_byte: got %h want %h", wb_data, exp_tab[4]); end
        tick();
    endtask

    task automatic test_arith();
        logic [31:0] exp_tab [4] = '{32'd7, 32'd5, 32'hFFFF_FFFB, 32'h0};
        logic [31:0] seq [4];
        seq[0] = enc_r(7'h00, 2, 1, 1);
        seq[1] = enc_r(7'h20, 2, 1, 1);
        seq[2] = enc_r(7'h20, 1, 0, 4);
        seq[3] = enc_i(1, 5, 0, 6, 7'h13);
        drive(enc_i(5, 0, 0, 1, 7'h13)); tick();
        drive(enc_i(2, 0, 0, 2, 7'h13)); tick();
        drive(enc_i(-1, 0, 0, 5, 7'h13)); tick();
        for (int k = 0; k < 4; k++) begin
            drive(seq[k]);
            vectors++;
            if ({wb_en, wb_data} !== {1'b1, exp_tab[k]}) begin
                miscompares++; $display("FAIL arith_%0d: got en=%b data=%h want 1/%h", k, wb_en, wb_data, exp_tab[k]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [31:0] p;
        drive(enc_i(5, 0, 0, 1, 7'h13)); tick();
        p = m_pc; drive(enc_b(24, 1, 0)); tick();
        vectors++;
        if (pc !== p + 32'd4) begin miscompares++; $display("FAIL beq_not_taken: got %h want %h", pc, p + 32'd4); end
        p = m_pc; drive(enc_b(24, 0, 0));
        vectors++;
        if (wb_en !== 1'b0) begin miscompares++; $display("FAIL beq_wb_en: got %b want 0", wb_en); end
        tick();
        vectors++;
        if (pc !== p + 32'd24) begin miscompares++; $display("FAIL beq_taken: got %h want %h", pc, p + 32'd24); end
        p = m_pc; drive(enc_j(4000, 1));
        vectors++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd1, p + 32'd4}) begin
            miscompares++; $display("FAIL jal_link: got en=%b rd=%0d data=%h want 1/1/%h", wb_en, wb_rd, wb_data, p + 32'd4);
        end
        tick();
        vectors++;
        if (pc !== p + 32'd4000) begin miscompares++; $display("FAIL jal_pc: got %h want %h", pc, p + 32'd4000); end
        p = m_pc; drive(enc_b(-8, 0, 0)); tick();
        vectors++;
        if (pc !== p - 32'd8) begin miscompares++; $display("FAIL beq_back: got %h want %h", pc, p - 32'd8); end
        p = m_pc; drive(enc_j(-4000, 0));
        vectors++;
        if (wb_en !== 1'b0) begin miscompares++; $display("FAIL jal_x0_en: got %b want 0", wb_en); end
        tick();
        vectors++;
        if (pc !== p - 32'd4000) begin miscompares++; $display("FAIL jal_back: got %h want %h", pc, p - 32'd4000); end
    endtask

    task automatic test_x0_illegal();
        logic [31:0] p;
        logic [31:0] bad [4];
        bad[0] = enc_i(7, 0, 0, 0, 7'h13);
        bad[1] = 32'h0000_007F;
        bad[2] = enc_i(1, 1, 1, 9, 7'h13);
        bad[3] = enc_r(7'h01, 2, 1, 9);
        for (int k = 0; k < 4; k++) begin
            p = m_pc; drive(bad[k]);
            vectors++;
            if (wb_en !== 1'b0) begin miscompares++; $display("FAIL nop_%0d_wb_en: got %b want 0", k, wb_en); end
            tick();
            vectors++;
            if (pc !== p + 32'd4) begin miscompares++; $display("FAIL nop_%0d_pc: got %h want %h", k, pc, p + 32'd4); end
        end
        drive(enc_i(0, 0, 0, 5, 7'h13));
        vectors++;
        if ({wb_en, wb_data} !== {1'b1, 32'h0}) begin
            miscompares++; $display("FAIL x0_zero: got en=%b data=%h want 1/0", wb_en, wb_data);
        end
        tick();
        drive(enc_s(0, 1, 0, 1)); tick();
        drive(enc_i(0, 0, 2, 9, 7'h03));
        vectors++;
        if (wb_data !== 32'h0) begin miscompares++; $display("FAIL sh_ignored: got %h want 00000000", wb_data); end
        tick();
    endtask

    task automatic test_hold();
        drive(enc_i(10, 0, 0, 1, 7'h13)); tick();
        drive(enc_i(1, 1, 0, 1, 7'h13));
        for (int k = 1; k <= 3; k++) begin
            vectors++;
            if (wb_data !== 32'(10 + k)) begin
                miscompares++; $display("FAIL hold_%0d: got %h want %h", k, wb_data, 32'(10 + k));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] instr;
        int kind, rd, r1, r2;
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 7));
            r1 = int'($urandom_range(0, 7));
            r2 = int'($urandom_range(0, 7));
            case (kind)
                1: instr = enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, r2, r1, rd);
                2: instr = enc_i($urandom_range(0, 63), 0, $urandom_range(0, 1) ? 2 : 0, rd, 7'h03);
                3: instr = enc_s($urandom_range(0, 63), r2, 0, $urandom_range(0, 1) ? 2 : 0);
                4: instr = enc_b((int'($urandom_range(0, 32)) - 16) * 2, r2 % 4, r1 % 4);
                5: instr = enc_j((int'($urandom_range(0, 64)) - 32) * 2, rd);
                6: instr = $urandom();
                default: instr = enc_i($urandom_range(0, 4095), r1, 0, rd, 7'h13);
            endcase
            drive(instr);
            vectors++;
            if (wb_en !== e_en) begin
                miscompares++; $display("FAIL rand_%0d_wb_en ir=%h: got %b want %b", n, instr, wb_en, e_en);
            end else if (e_en && {wb_rd, wb_data} !== {e_rd, e_data}) begin
                miscompares++; $display("FAIL rand_%0d_wb ir=%h: got rd=%0d data=%h want rd=%0d data=%h",
                                        n, instr, wb_rd, wb_data, e_rd, e_data);
            end
            tick();
            vectors++;
            if (pc !== m_pc) begin miscompares++; $display("FAIL rand_%0d_pc ir=%h: got %h want %h", n, instr, pc, m_pc); end
        end
    endtask

    task automatic test_reset_priority();
        drive(enc_i(77, 0, 0, 1, 7'h13)); tick();
        drive(enc_s(16, 1, 0, 2));
        reset = 1'b0;
        tick();
        vectors++;
        if (pc !== 32'h0) begin miscompares++; $display("FAIL rstpri_pc: got %h want 00000000", pc); end
        reset = 1'b1;
        drive(enc_i(16, 0, 2, 2, 7'h03));
        vectors++;
        if (wb_data !== 32'h0) begin miscompares++; $display("FAIL rstpri_store: got %h want 00000000", wb_data); end
        tick();
        drive(enc_i(0, 1, 0, 3, 7'h13));
        vectors++;
        if (wb_data !== 32'h0) begin miscompares++; $display("FAIL rstpri_regs: got %h want 00000000", wb_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_mem();
        test_arith();
        test_branch();
        test_x0_illegal();
        test_hold();
        test_random();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
